// File: rtl/regfile_sb.sv
// Register file with a write-through bypass, a pending-write scoreboard and an overflow flag bit.
// Register 0 always reads as zero. Bit 0 of FLAG_REG holds the ALU overflow status.
module regfile_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int FLAG_REG = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_pend,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              pend_set,
  input  logic [AW-1:0]     pend_addr,
  input  logic              of_en,
  input  logic              of_flag,
  output logic [AW:0]       pend_cnt
);

  localparam int            DEPTH  = 2 ** AW;
  localparam logic [AW-1:0] FLAG_A = AW'(FLAG_REG);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [AW:0] cnt_q, cnt_d;

  logic wr_ok, set_ok, set_rise, clr_fall;

  assign wr_ok  = wr_en && (wr_addr != '0);
  assign set_ok = pend_set && (pend_addr != '0);

  // A set to the register being cleared this cycle wins, so that register never falls.
  assign set_rise = set_ok && !pend_q[pend_addr];
  assign clr_fall = wr_ok && pend_q[wr_addr] && !(set_ok && (pend_addr == wr_addr));

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
    if (of_en) begin
      mem_d[FLAG_REG][0] = of_flag;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (wr_ok) begin
      pend_d[wr_addr] = 1'b0;
    end
    if (set_ok) begin
      pend_d[pend_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q + (AW + 1)'(set_rise) - (AW + 1)'(clr_fall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          hit;

    assign addr = rd_addr[k*AW +: AW];
    assign hit  = wr_en && (wr_addr == addr);

    always_comb begin
      data = mem_q[addr];
      if (addr == '0) begin
        data = '0;
      end else if (hit) begin
        data = wr_data;
        if ((addr == FLAG_A) && of_en) begin
          data[0] = of_flag;
        end
      end else if ((addr == FLAG_A) && of_en) begin
        data[0] = of_flag;
      end
    end

    assign rd_data[k*DW +: DW] = data;
    assign rd_pend[k]          = pend_q[addr] && !hit;
  end

endmodule
